inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage directly downstream of the BPIF pipeline register.
- Takes the current PC and branch-prediction metadata, issues a single-outstanding read to the instruction memory port, and presents the returned instruction plus PC and prediction info to the IF/ID register.
- Generates the back-pressure stall request for the PC/PCBP/BP/BPIF front end and handles flushes while a fetch is in flight.

Parameters:
GHR_WIDTH, 5, width of the PHT index carried with each instruction (matches GHR_BUS).

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
flush  input  1  pipeline flush (branch miss or exception)
stall_next_stage  input  1  IF/ID cannot accept; output register must hold
valid_in  input  1  current_pc_in is a real fetch request
current_pc_in  input  32  PC to fetch (from BPIF)
next_pc_in  input  32  predicted next PC (from BPIF)
is_branch_taken_in  input  1  prediction taken flag (from BPIF)
current_pht_index_in  input  GHR_WIDTH  PHT index used for prediction
mem_req  output  1  fetch request valid
mem_addr  output  32  fetch address
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  instruction word
stall_request  output  1  front end must hold its current outputs
valid_out  output  1  inst_out/pc_out valid for decode
inst_out  output  32  fetched instruction
pc_out  output  32  PC of inst_out
next_pc_out  output  32  predicted next PC travelling with inst_out
is_branch_taken_out  output  1  prediction flag travelling with inst_out
pht_index_out  output  GHR_WIDTH  PHT index travelling with inst_out
addr_err_out  output  1  current_pc_in was misaligned; inst_out = 0

Behaviour:
- Reset (rst=0 at posedge): state IDLE. All registered outputs = 0. mem_req=0, stall_request=0.
- States: IDLE, WAIT (request granted, awaiting rvalid), HOLD (data received, downstream stalled), DISCARD (flushed while in flight).
- mem_req/mem_addr are combinational.
  - mem_req = (state==IDLE) & valid_in & !flush & (current_pc_in[1:0]==0).
  - mem_addr = current_pc_in.
- IDLE, aligned request:
  - mem_gnt=1: capture pc/next_pc/taken/pht_index into the side register; go WAIT.
  - mem_gnt=0: stall_request=1; stay IDLE. Upstream holds its inputs stable.
- IDLE, misaligned (valid_in & pc[1:0]!=0 & !flush):
  - No memory request.
  - If !stall_next_stage: next cycle valid_out=1, addr_err_out=1, inst_out=0, other fields from inputs.
  - Otherwise stall_request=1 and wait.
- WAIT: stall_request=1.
  - mem_rvalid & !stall_next_stage: output register loads rdata plus side fields, valid_out=1, addr_err_out=0; go IDLE.
  - mem_rvalid & stall_next_stage: rdata goes into the hold buffer; go HOLD.
- HOLD: stall_request=1. When stall_next_stage=0, load the output register from the hold buffer; go IDLE.
- Latency: grant at cycle T, rvalid at T+k (k≥1), valid_out at T+k+1.
- Output register:
  - Frozen while stall_next_stage=1.
  - When stall_next_stage=0 and nothing new is loaded, valid_out=0 next cycle.
  - stall_request in IDLE for a successful issue is 0, so the front end advances the same cycle as the grant.
- Flush (highest priority):
  - Output register valid_out cleared next cycle.
  - IDLE: no request issued.
  - WAIT without rvalid: go DISCARD.
  - WAIT with rvalid same cycle: drop data; go IDLE.
  - HOLD: drop buffer; go IDLE.
  - DISCARD ignores flush.
- DISCARD: stall_request=1, mem_req=0. On mem_rvalid, drop data and go IDLE.
  - Only one outstanding request ever; a new PC is issued only from IDLE.
- flush and stall_next_stage together: flush wins, valid_out=0.
- valid_in=0 in IDLE: no request, stall_request=0.

Test Plan:
- Reset, then valid_in=1, pc=0xBFC00000, gnt=1 immediately, rvalid+rdata=0x24080001 one cycle later → mem_req high one cycle; valid_out=1 with inst_out=0x24080001, pc_out=0xBFC00000 two cycles after grant; stall_request=1 only in WAIT.
- gnt withheld 3 cycles for pc=0x100 → stall_request=1 and mem_addr=0x100 stable for 3 cycles; issue on the 4th cycle.
- rvalid arrives while stall_next_stage=1 for 2 cycles → state HOLD; valid_out/inst_out frozen at the previous value; new instruction appears the cycle after stall drops; no data loss.
- flush one cycle after grant, rvalid 2 cycles later with 0xDEADBEEF → DISCARD; 0xDEADBEEF never on inst_out; valid_out=0; next request for flushed PC 0x200 issues only after rvalid.
- pc=0x102 → no mem_req; next cycle valid_out=1, addr_err_out=1, inst_out=0, pc_out=0x102.
- rst=0 asserted while in WAIT → next cycle all outputs 0, state IDLE, later stray rvalid ignored.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction-memory port of the fetch stage.
//   mem_req    : fetch request valid (fetch stage -> memory)
//   mem_addr   : fetch address        (fetch stage -> memory)
//   mem_gnt    : request accepted this cycle   (memory -> fetch stage)
//   mem_rvalid : read data valid               (memory -> fetch stage)
//   mem_rdata  : instruction word              (memory -> fetch stage)
interface inst_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage between the BPIF register and the IF/ID register.
// Issues one outstanding read per PC, returns the instruction with its PC and
// branch-prediction metadata, back-pressures the front end and absorbs flushes
// that land while a fetch is in flight.
//   clk, rst                : clock, synchronous active-low reset
//   flush                   : kill the instruction in flight / in the output
//   stall_next_stage        : IF/ID cannot accept; output register holds
//   valid_in, current_pc_in, next_pc_in, is_branch_taken_in,
//   current_pht_index_in    : fetch request and prediction info from BPIF
//   mem                     : instruction-memory port (req/addr/gnt/rvalid/rdata)
//   stall_request           : front end must hold its outputs
//   valid_out, inst_out, pc_out, next_pc_out, is_branch_taken_out,
//   pht_index_out, addr_err_out : registered result for decode
module inst_fetch #(
  parameter int unsigned GHR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 stall_next_stage,
  input  logic                 valid_in,
  input  logic [31:0]          current_pc_in,
  input  logic [31:0]          next_pc_in,
  input  logic                 is_branch_taken_in,
  input  logic [GHR_WIDTH-1:0] current_pht_index_in,
  inst_fetch_if.master         mem,
  output logic                 stall_request,
  output logic                 valid_out,
  output logic [31:0]          inst_out,
  output logic [31:0]          pc_out,
  output logic [31:0]          next_pc_out,
  output logic                 is_branch_taken_out,
  output logic [GHR_WIDTH-1:0] pht_index_out,
  output logic                 addr_err_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t               r_state;
  // Metadata of the PC in flight (front end has moved on after the grant)
  logic [31:0]          r_pc;
  logic [31:0]          r_npc;
  logic                 r_tk;
  logic [GHR_WIDTH-1:0] r_pht;
  logic [31:0]          r_hold_data;

  logic                 r_valid_out;
  logic [31:0]          r_inst_out;
  logic [31:0]          r_pc_out;
  logic [31:0]          r_npc_out;
  logic                 r_tk_out;
  logic [GHR_WIDTH-1:0] r_pht_out;
  logic                 r_err_out;

  logic                 w_aligned;
  logic                 w_issue;
  logic                 w_misal;
  logic                 w_load;
  logic [31:0]          w_ld_inst;
  logic [31:0]          w_ld_pc;
  logic [31:0]          w_ld_npc;
  logic                 w_ld_tk;
  logic [GHR_WIDTH-1:0] w_ld_pht;
  logic                 w_ld_err;

  assign w_aligned = (current_pc_in[1:0] == 2'b00);
  assign w_issue   = (r_state == S_IDLE) & valid_in & ~flush &  w_aligned;
  assign w_misal   = (r_state == S_IDLE) & valid_in & ~flush & ~w_aligned;

  assign mem.mem_req  = rst & w_issue;
  assign mem.mem_addr = current_pc_in;

  // IDLE stalls only while waiting for a grant or an IF/ID slot for an
  // address error; every other state owns the single outstanding slot.
  assign stall_request = rst & ((r_state != S_IDLE) |
                                (w_issue & ~mem.mem_gnt) |
                                (w_misal & stall_next_stage));

  // Source and enable for the output register
  always_comb begin
    w_load    = 1'b0;
    w_ld_inst = mem.mem_rdata;
    w_ld_pc   = r_pc;
    w_ld_npc  = r_npc;
    w_ld_tk   = r_tk;
    w_ld_pht  = r_pht;
    w_ld_err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_load    = w_misal & ~stall_next_stage;
        w_ld_inst = '0;
        w_ld_pc   = current_pc_in;
        w_ld_npc  = next_pc_in;
        w_ld_tk   = is_branch_taken_in;
        w_ld_pht  = current_pht_index_in;
        w_ld_err  = 1'b1;
      end
      S_WAIT:    w_load = mem.mem_rvalid & ~flush & ~stall_next_stage;
      S_HOLD: begin
        w_load    = ~flush & ~stall_next_stage;
        w_ld_inst = r_hold_data;
      end
      default:   w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_npc       <= '0;
      r_tk        <= 1'b0;
      r_pht       <= '0;
      r_hold_data <= '0;
      r_valid_out <= 1'b0;
      r_inst_out  <= '0;
      r_pc_out    <= '0;
      r_npc_out   <= '0;
      r_tk_out    <= 1'b0;
      r_pht_out   <= '0;
      r_err_out   <= 1'b0;
    end else begin
      // Flush beats stall: the output is invalidated even while frozen
      if (flush || !stall_next_stage) r_valid_out <= 1'b0;
      if (w_load) begin
        r_valid_out <= 1'b1;
        r_inst_out  <= w_ld_inst;
        r_pc_out    <= w_ld_pc;
        r_npc_out   <= w_ld_npc;
        r_tk_out    <= w_ld_tk;
        r_pht_out   <= w_ld_pht;
        r_err_out   <= w_ld_err;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_issue && mem.mem_gnt) begin
            r_pc    <= current_pc_in;
            r_npc   <= next_pc_in;
            r_tk    <= is_branch_taken_in;
            r_pht   <= current_pht_index_in;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_rvalid) begin
            if (!flush && stall_next_stage) begin
              r_hold_data <= mem.mem_rdata;
              r_state     <= S_HOLD;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (flush) begin
            r_state <= S_DISCARD;
          end
        end
        S_HOLD: begin
          if (flush || !stall_next_stage) r_state <= S_IDLE;
        end
        S_DISCARD: begin
          if (mem.mem_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid_out           = r_valid_out;
  assign inst_out            = r_inst_out;
  assign pc_out              = r_pc_out;
  assign next_pc_out         = r_npc_out;
  assign is_branch_taken_out = r_tk_out;
  assign pht_index_out       = r_pht_out;
  assign addr_err_out        = r_err_out;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_inst_fetch;
  localparam int unsigned GW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          stall_next_stage = 1'b0;
  logic          valid_in = 1'b0;
  logic [31:0]   current_pc_in = '0;
  logic [31:0]   next_pc_in = '0;
  logic          is_branch_taken_in = 1'b0;
  logic [GW-1:0] current_pht_index_in = '0;
  logic          stall_request;
  logic          valid_out;
  logic [31:0]   inst_out;
  logic [31:0]   pc_out;
  logic [31:0]   next_pc_out;
  logic          is_branch_taken_out;
  logic [GW-1:0] pht_index_out;
  logic          addr_err_out;

  inst_fetch_if mif ();

  inst_fetch #(.GHR_WIDTH(GW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .stall_next_stage     (stall_next_stage),
    .valid_in             (valid_in),
    .current_pc_in        (current_pc_in),
    .next_pc_in           (next_pc_in),
    .is_branch_taken_in   (is_branch_taken_in),
    .current_pht_index_in (current_pht_index_in),
    .mem                  (mif.master),
    .stall_request        (stall_request),
    .valid_out            (valid_out),
    .inst_out             (inst_out),
    .pc_out               (pc_out),
    .next_pc_out          (next_pc_out),
    .is_branch_taken_out  (is_branch_taken_out),
    .pht_index_out        (pht_index_out),
    .addr_err_out         (addr_err_out)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   npc;
    logic          tk;
    logic [GW-1:0] pht;
  } meta_t;

  typedef struct packed {
    logic        v;
    logic [31:0] inst;
    meta_t       m;
    logic        err;
  } out_t;

  // Reference model: one fetch slot that may be outstanding, killed, or
  // holding returned data, plus the expected IF/ID register contents.
  bit          busy = 0;
  bit          dropped = 0;
  bit          buffered = 0;
  logic [31:0] buf_d = '0;
  meta_t       flight = '0;
  out_t        eo = '0;
  bit          last_stall = 0;

  // Memory responder
  bit          m_busy = 0;
  int unsigned m_cnt = 0;
  logic [31:0] m_data = '0;
  int unsigned lat_force = 1;
  bit          data_force_en = 1;
  logic [31:0] data_force = '0;
  bit          gnt_random = 0;

  function automatic meta_t cur_meta();
    return {current_pc_in, next_pc_in, is_branch_taken_in, current_pht_index_in};
  endfunction

  task automatic step();
    bit idle, al, er, es, full_cmp;
    @(negedge clk);
    idle = !busy && !buffered;
    al   = (current_pc_in[1:0] == 2'b00);
    er   = rst && idle && valid_in && !flush && al;
    es   = rst && (!idle || (valid_in && !flush && (al ? !mif.mem_gnt : stall_next_stage)));
    check("mem_req", 32'(mif.mem_req), 32'(er));
    if (er) check("mem_addr", mif.mem_addr, current_pc_in);
    check("stall_request", 32'(stall_request), 32'(es));
    last_stall = es;

    if (mif.mem_req && mif.mem_gnt) begin
      m_busy = 1;
      m_cnt  = (lat_force != 0) ? lat_force : $urandom_range(1, 4);
      m_data = data_force_en ? data_force : $urandom;
    end

    full_cmp = !rst;
    if (!rst) begin
      busy = 0; dropped = 0; buffered = 0; eo = '0;
    end else begin
      if (flush || !stall_next_stage) eo.v = 1'b0;
      if (busy) begin
        if (mif.mem_rvalid) begin
          busy = 0;
          if (dropped || flush) dropped = 0;
          else if (!stall_next_stage) eo = {1'b1, mif.mem_rdata, flight, 1'b0};
          else begin buffered = 1; buf_d = mif.mem_rdata; end
        end else if (flush) begin
          dropped = 1;
        end
      end else if (buffered) begin
        if (flush) buffered = 0;
        else if (!stall_next_stage) begin
          eo = {1'b1, buf_d, flight, 1'b0};
          buffered = 0;
        end
      end else if (valid_in && !flush) begin
        if (al) begin
          if (mif.mem_gnt) begin busy = 1; flight = cur_meta(); end
        end else if (!stall_next_stage) begin
          eo = {1'b1, 32'h0, cur_meta(), 1'b1};
        end
      end
    end

    @(posedge clk);
    #1;
    check("valid_out", 32'(valid_out), 32'(eo.v));
    if (eo.v || full_cmp) begin
      check("inst_out", inst_out, eo.inst);
      check("pc_out", pc_out, eo.m.pc);
      check("next_pc_out", next_pc_out, eo.m.npc);
      check("taken_out", 32'(is_branch_taken_out), 32'(eo.m.tk));
      check("pht_out", 32'(pht_index_out), 32'(eo.m.pht));
      check("addr_err_out", 32'(addr_err_out), 32'(eo.err));
    end

    mif.mem_rvalid = 1'b0;
    mif.mem_rdata  = $urandom;
    if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = m_data;
        m_busy = 0;
      end
    end
    if (gnt_random) mif.mem_gnt = ($urandom_range(0, 9) < 6);
  endtask

  task automatic set_req(input logic v, input logic [31:0] pc);
    valid_in             = v;
    current_pc_in        = pc;
    next_pc_in           = pc + 32'd4;
    is_branch_taken_in   = pc[4];
    current_pht_index_in = pc[GW+1:2];
  endtask

  initial begin
    logic [31:0] r;
    bit          last_flush;
    mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;

    // Reset
    set_req(1'b1, 32'h0000_0040);
    step(); step();

    // Basic fetch, grant immediate, rvalid one cycle later
    rst = 1'b1;
    set_req(1'b1, 32'hBFC0_0000); mif.mem_gnt = 1'b1;
    lat_force = 1; data_force = 32'h2408_0001;
    step();
    set_req(1'b0, 32'h0); mif.mem_gnt = 1'b0;
    step();
    check("tp1_inst", inst_out, 32'h2408_0001);
    check("tp1_pc", pc_out, 32'hBFC0_0000);
    step();

    // Grant withheld three cycles
    set_req(1'b1, 32'h0000_0100);
    repeat (3) step();
    mif.mem_gnt = 1'b1; data_force = 32'h0A0B_0C0D; lat_force = 2;
    step();
    set_req(1'b0, 32'h0); mif.mem_gnt = 1'b0;
    repeat (3) step();

    // Data returns while IF/ID is stalled
    set_req(1'b1, 32'h0000_0300); mif.mem_gnt = 1'b1; lat_force = 1;
    data_force = 32'h1111_2222; stall_next_stage = 1'b1;
    step();
    set_req(1'b0, 32'h0); mif.mem_gnt = 1'b0;
    step(); step();
    stall_next_stage = 1'b0;
    step();
    check("tp3_inst", inst_out, 32'h1111_2222);
    step();

    // Flush while in flight: returned word is discarded
    set_req(1'b1, 32'h0000_0200); mif.mem_gnt = 1'b1; lat_force = 3;
    data_force = 32'hDEAD_BEEF;
    step();
    mif.mem_gnt = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    step(); step();
    mif.mem_gnt = 1'b1; lat_force = 1; data_force = 32'h2222_3333;
    step();
    set_req(1'b0, 32'h0); mif.mem_gnt = 1'b0;
    step();
    check("tp4_no_deadbeef", 32'(inst_out == 32'hDEAD_BEEF), 32'd0);
    check("tp4_inst", inst_out, 32'h2222_3333);

    // Misaligned PC
    set_req(1'b1, 32'h0000_0102);
    step();
    check("tp5_err", 32'(addr_err_out), 32'd1);
    check("tp5_inst", inst_out, 32'h0);
    check("tp5_pc", pc_out, 32'h0000_0102);
    set_req(1'b0, 32'h0);
    step();

    // Reset while waiting; the late response must be ignored
    set_req(1'b1, 32'h0000_0400); mif.mem_gnt = 1'b1; lat_force = 3;
    data_force = 32'h5555_AAAA;
    step();
    set_req(1'b0, 32'h0); mif.mem_gnt = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) step();
    check("tp6_no_stray", 32'(valid_out), 32'd0);

    // Random traffic
    gnt_random = 1; lat_force = 0; data_force_en = 0;
    last_flush = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall || last_flush) begin
        r = $urandom;
        set_req(($urandom_range(0, 9) < 8),
                {r[31:2], ($urandom_range(0, 7) == 0) ? r[1:0] : 2'b00});
      end
      flush            = ($urandom_range(0, 11) == 0);
      stall_next_stage = ($urandom_range(0, 9) < 3);
      rst              = ($urandom_range(0, 499) != 0);
      last_flush       = flush;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
